// File: rtl/io_channel_bank_pkg.sv
// Shared constants and helpers for the I/O channel bank.
// Priority mode encodings and channel-index width calculation.
package io_channel_bank_pkg;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Channel index width, never narrower than one bit
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/io_channel_bank_io_channel.sv
// One I/O channel: input register/flag, output register/flag,
// and a sticky input-overrun flag.
module io_channel #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_out_ready,
   input  logic              i_rd,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_bus,
   output logic [DATA_W-1:0] o_inpr,
   output logic              o_fgi,
   output logic [DATA_W-1:0] o_outr,
   output logic              o_fgo,
   output logic              o_ovr
);

   logic [DATA_W-1:0] r_inpr;
   logic              r_fgi;
   logic [DATA_W-1:0] r_outr;
   logic              r_fgo;
   logic              r_ovr;

   // Input side: a device byte lands when the flag is free or
   // being read this cycle; otherwise it is dropped as an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inpr <= '0;
         r_fgi  <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (i_in_valid && (!r_fgi || i_rd)) begin
            r_inpr <= i_in_data;
            r_fgi  <= 1'b1;
         end else if (i_rd) begin
            r_fgi  <= 1'b0;
         end
         if (i_rd) begin
            r_ovr <= 1'b0;
         end else if (i_in_valid && r_fgi) begin
            r_ovr <= 1'b1;
         end
      end
   end

   // Output side: CPU writes only while the device is ready,
   // the device re-arms the flag once it has consumed the byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outr <= '0;
         r_fgo  <= 1'b1;
      end else begin
         if (i_wr && r_fgo) begin
            r_outr <= i_bus;
            r_fgo  <= 1'b0;
         end else if (i_out_ready && !r_fgo) begin
            r_fgo  <= 1'b1;
         end
      end
   end

   assign o_inpr = r_inpr;
   assign o_fgi  = r_fgi;
   assign o_outr = r_outr;
   assign o_fgo  = r_fgo;
   assign o_ovr  = r_ovr;

endmodule

// File: rtl/io_channel_bank.sv
// Bank of I/O channels with CPU select/strobe access,
// interrupt enable, interrupt flip-flop and channel arbitration.
module io_channel_bank
   import io_channel_bank_pkg::*;
#(
   parameter  int NUM_CH    = 2,
   parameter  int DATA_W    = 8,
   parameter  int PRIO_MODE = PRIO_FIXED,
   localparam int CH_W      = ch_w(NUM_CH)
) (
   input  logic                     myclock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_in_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
   input  logic [NUM_CH-1:0]        ch_out_ready,
   output logic [NUM_CH*DATA_W-1:0] ch_out_data,
   output logic [NUM_CH-1:0]        ch_out_valid,
   input  logic [CH_W-1:0]          sel,
   input  logic [DATA_W-1:0]        bus_in,
   input  logic                     cpu_inp,
   input  logic                     cpu_out,
   input  logic                     cpu_ion,
   input  logic                     cpu_iof,
   output logic [DATA_W-1:0]        inp_data,
   output logic                     fgi_sel,
   output logic                     fgo_sel,
   input  logic                     r_sample,
   input  logic                     int_ack,
   output logic                     r_out,
   output logic [CH_W-1:0]          int_vec,
   output logic                     ien_out,
   output logic [NUM_CH-1:0]        overrun
);

   logic [NUM_CH-1:0] w_sel_hit;
   logic [NUM_CH-1:0] w_fgi;
   logic [NUM_CH-1:0] w_fgo;
   logic [NUM_CH-1:0] w_ovr;
   logic [NUM_CH-1:0] w_pending;
   logic [DATA_W-1:0] w_inpr [NUM_CH];
   logic [DATA_W-1:0] w_outr [NUM_CH];
   logic [CH_W-1:0]   w_win;
   logic              w_found;
   int                w_idx;

   logic              r_ien;
   logic              r_r;
   logic [CH_W-1:0]   r_int_vec;
   logic [CH_W-1:0]   r_rr_ptr;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_sel_hit[k] = (sel == CH_W'(k));

      io_channel #(
         .DATA_W (DATA_W)
      ) u_ch (
         .clk         (myclock),
         .rst         (reset),
         .i_in_valid  (ch_in_valid[k]),
         .i_in_data   (ch_in_data[k*DATA_W +: DATA_W]),
         .i_out_ready (ch_out_ready[k]),
         .i_rd        (cpu_inp & w_sel_hit[k]),
         .i_wr        (cpu_out & w_sel_hit[k]),
         .i_bus       (bus_in),
         .o_inpr      (w_inpr[k]),
         .o_fgi       (w_fgi[k]),
         .o_outr      (w_outr[k]),
         .o_fgo       (w_fgo[k]),
         .o_ovr       (w_ovr[k])
      );

      assign ch_out_data[k*DATA_W +: DATA_W] = w_outr[k];
   end

   assign w_pending    = w_fgi | w_fgo;
   assign ch_out_valid = ~w_fgo;
   assign overrun      = w_ovr;

   // CPU read mux; an out-of-range select matches no channel and reads 0
   always_comb begin
      inp_data = '0;
      fgi_sel  = 1'b0;
      fgo_sel  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_sel_hit[k]) begin
            inp_data = inp_data | w_inpr[k];
            fgi_sel  = fgi_sel | w_fgi[k];
            fgo_sel  = fgo_sel | w_fgo[k];
         end
      end
   end

   // Winner search: scan from 0 (fixed) or from rr_ptr with wrap (round-robin)
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (PRIO_MODE == PRIO_RR) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_CH;
         end else begin
            w_idx = i;
         end
         for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && w_pending[j] && (j == w_idx)) begin
               w_found = 1'b1;
               w_win   = CH_W'(j);
            end
         end
      end
   end

   // IEN/R control: acknowledge dominates, vector frozen while R is set
   always_ff @(posedge myclock or posedge reset) begin
      if (reset) begin
         r_ien     <= 1'b0;
         r_r       <= 1'b0;
         r_int_vec <= '0;
         r_rr_ptr  <= '0;
      end else if (int_ack) begin
         r_ien <= 1'b0;
         r_r   <= 1'b0;
         if (PRIO_MODE == PRIO_RR) begin
            r_rr_ptr <= CH_W'((int'(r_int_vec) + 1) % NUM_CH);
         end
      end else begin
         if (cpu_iof) begin
            r_ien <= 1'b0;
         end else if (cpu_ion) begin
            r_ien <= 1'b1;
         end
         if (r_sample && r_ien && (|w_pending) && !r_r) begin
            r_r       <= 1'b1;
            r_int_vec <= w_win;
         end
      end
   end

   assign r_out   = r_r;
   assign int_vec = r_int_vec;
   assign ien_out = r_ien;

endmodule

// File: tb/tb_io_channel_bank.sv
// Directed scoreboard bench for io_channel_bank: a 2-channel fixed
// priority instance and a 4-channel round-robin instance.
module tb_io_channel_bank;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // Instance A: NUM_CH=2, fixed priority
   logic [1:0]  a_in_valid, a_out_ready, a_out_valid, a_ovr;
   logic [15:0] a_in_data, a_out_data;
   logic [0:0]  a_sel, a_vec;
   logic [7:0]  a_bus, a_inp_data;
   logic        a_inp, a_out, a_ion, a_iof;
   logic        a_fgi_sel, a_fgo_sel, a_rs, a_ack, a_r, a_ien;

   // Instance B: NUM_CH=4, round-robin
   logic [3:0]  b_in_valid, b_out_ready, b_out_valid, b_ovr;
   logic [31:0] b_in_data, b_out_data;
   logic [1:0]  b_sel, b_vec;
   logic [7:0]  b_bus, b_inp_data;
   logic        b_inp, b_out, b_ion, b_iof;
   logic        b_fgi_sel, b_fgo_sel, b_rs, b_ack, b_r, b_ien;

   io_channel_bank #(.NUM_CH(2), .DATA_W(8), .PRIO_MODE(0)) u_a (
      .myclock(clk), .reset(rst),
      .ch_in_valid(a_in_valid), .ch_in_data(a_in_data),
      .ch_out_ready(a_out_ready), .ch_out_data(a_out_data),
      .ch_out_valid(a_out_valid), .sel(a_sel), .bus_in(a_bus),
      .cpu_inp(a_inp), .cpu_out(a_out), .cpu_ion(a_ion),
      .cpu_iof(a_iof), .inp_data(a_inp_data), .fgi_sel(a_fgi_sel),
      .fgo_sel(a_fgo_sel), .r_sample(a_rs), .int_ack(a_ack),
      .r_out(a_r), .int_vec(a_vec), .ien_out(a_ien), .overrun(a_ovr)
   );

   io_channel_bank #(.NUM_CH(4), .DATA_W(8), .PRIO_MODE(1)) u_b (
      .myclock(clk), .reset(rst),
      .ch_in_valid(b_in_valid), .ch_in_data(b_in_data),
      .ch_out_ready(b_out_ready), .ch_out_data(b_out_data),
      .ch_out_valid(b_out_valid), .sel(b_sel), .bus_in(b_bus),
      .cpu_inp(b_inp), .cpu_out(b_out), .cpu_ion(b_ion),
      .cpu_iof(b_iof), .inp_data(b_inp_data), .fgi_sel(b_fgi_sel),
      .fgo_sel(b_fgo_sel), .r_sample(b_rs), .int_ack(b_ack),
      .r_out(b_r), .int_vec(b_vec), .ien_out(b_ien), .overrun(b_ovr)
   );

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.v   = v;
      sbq.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: got %0h required an entry", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", e.tag, obs, e.v);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   logic [1:0] rr_exp [4];

   initial begin
      rr_exp = '{2'd0, 2'd2, 2'd0, 2'd2};
      {a_in_valid, a_in_data, a_out_ready, a_sel, a_bus} = '0;
      {a_inp, a_out, a_ion, a_iof, a_rs, a_ack} = '0;
      {b_in_valid, b_in_data, b_out_ready, b_sel, b_bus} = '0;
      {b_inp, b_out, b_ion, b_iof, b_rs, b_ack} = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      push("rst_r", 0);        chk(a_r);
      push("rst_ien", 0);      chk(a_ien);
      push("rst_vec", 0);      chk(a_vec);
      push("rst_ovalid", 0);   chk(a_out_valid);
      push("rst_odata", 0);    chk(a_out_data);
      push("rst_ovr", 0);      chk(a_ovr);
      push("rst_fgo_sel", 1);  chk(a_fgo_sel);
      push("rst_fgi_sel", 0);  chk(a_fgi_sel);

      // Input on channel 1, then CPU read
      a_sel = 1'b1;
      a_in_valid = 2'b10;
      a_in_data = 16'h4100;
      tick();
      a_in_valid = 2'b00;
      push("in1_fgi", 1);      chk(a_fgi_sel);
      push("in1_data", 8'h41); chk(a_inp_data);
      a_inp = 1'b1;
      tick();
      a_inp = 1'b0;
      push("in1_fgi_clr", 0);  chk(a_fgi_sel);

      // Overrun on channel 0
      a_sel = 1'b0;
      a_in_valid = 2'b01;
      a_in_data = 16'h0033;
      tick();
      a_in_data = 16'h0055;
      tick();
      a_in_valid = 2'b00;
      push("ovr_data", 8'h33); chk(a_inp_data);
      push("ovr_set", 2'b01);  chk(a_ovr);
      tick();
      push("ovr_sticky", 2'b01); chk(a_ovr);
      a_inp = 1'b1;
      tick();
      a_inp = 1'b0;
      push("ovr_clr", 0);      chk(a_ovr);
      push("ovr_fgi_clr", 0);  chk(a_fgi_sel);

      // Read coinciding with new input: set wins, no overrun
      a_in_valid = 2'b01;
      a_in_data = 16'h0011;
      tick();
      a_inp = 1'b1;
      a_in_data = 16'h0022;
      tick();
      a_inp = 1'b0;
      a_in_valid = 2'b00;
      push("rdset_fgi", 1);     chk(a_fgi_sel);
      push("rdset_data", 8'h22); chk(a_inp_data);
      push("rdset_ovr", 0);     chk(a_ovr);
      a_inp = 1'b1;
      tick();
      a_inp = 1'b0;

      // Output path on channel 0
      a_bus = 8'h7E;
      a_out = 1'b1;
      tick();
      a_out = 1'b0;
      push("out_valid", 2'b01); chk(a_out_valid);
      push("out_data", 8'h7E);  chk(a_out_data[7:0]);
      push("out_fgo", 0);       chk(a_fgo_sel);
      a_bus = 8'h99;
      a_out = 1'b1;
      tick();
      a_out = 1'b0;
      push("out_ignored", 8'h7E); chk(a_out_data[7:0]);
      a_out_ready = 2'b01;
      tick();
      a_out_ready = 2'b00;
      push("out_ready_v", 0);   chk(a_out_valid);
      push("out_ready_fgo", 1); chk(a_fgo_sel);

      // Interrupt with both inputs pending, fixed priority
      a_in_valid = 2'b11;
      a_in_data = 16'h0102;
      tick();
      a_in_valid = 2'b00;
      a_ion = 1'b1;
      tick();
      a_ion = 1'b0;
      push("ion_ien", 1);      chk(a_ien);
      push("ion_r_nosamp", 0); chk(a_r);
      a_rs = 1'b1;
      tick();
      a_rs = 1'b0;
      push("int_r", 1);        chk(a_r);
      push("int_vec", 0);      chk(a_vec);
      a_ack = 1'b1;
      tick();
      a_ack = 1'b0;
      push("ack_r", 0);        chk(a_r);
      push("ack_ien", 0);      chk(a_ien);

      // ION/IOF together, and ack against ION
      a_ion = 1'b1;
      tick();
      a_iof = 1'b1;
      tick();
      a_ion = 1'b0;
      a_iof = 1'b0;
      push("ionf_clr", 0);     chk(a_ien);
      a_ion = 1'b1;
      a_ack = 1'b1;
      tick();
      a_ion = 1'b0;
      a_ack = 1'b0;
      push("ack_vs_ion", 0);   chk(a_ien);

      // Asynchronous reset while R=1 and FGO[1]=0
      a_ion = 1'b1;
      tick();
      a_ion = 1'b0;
      a_rs = 1'b1;
      tick();
      a_rs = 1'b0;
      a_sel = 1'b1;
      a_bus = 8'h5A;
      a_out = 1'b1;
      tick();
      a_out = 1'b0;
      push("pre_rst_r", 1);       chk(a_r);
      push("pre_rst_ov", 2'b10);  chk(a_out_valid);
      #1;
      rst = 1'b1;
      #1;
      push("arst_r", 0);       chk(a_r);
      push("arst_ien", 0);     chk(a_ien);
      push("arst_ov", 0);      chk(a_out_valid);
      push("arst_fgi", 0);     chk(a_fgi_sel);
      push("arst_inp", 0);     chk(a_inp_data);
      push("arst_odata", 0);   chk(a_out_data);
      tick();
      rst = 1'b0;
      tick();

      // Round-robin: only channels 0 and 2 pending
      b_out = 1'b1;
      b_bus = 8'hA5;
      b_sel = 2'd1;
      tick();
      b_sel = 2'd3;
      tick();
      b_out = 1'b0;
      push("rr_ovalid", 4'b1010); chk(b_out_valid);
      b_ion = 1'b1;
      tick();
      b_ion = 1'b0;
      for (int r = 0; r < 4; r++) begin
         b_rs = 1'b1;
         tick();
         b_rs = 1'b0;
         push($sformatf("rr_r%0d", r), 1);         chk(b_r);
         push($sformatf("rr_vec%0d", r), rr_exp[r]); chk(b_vec);
         b_ack = 1'b1;
         tick();
         b_ack = 1'b0;
         push($sformatf("rr_ack%0d", r), 0);       chk(b_r);
         b_ion = 1'b1;
         tick();
         b_ion = 1'b0;
      end

      if (sbq.size() != 0) begin
         errors++;
         checks++;
         $error("FAIL sb_leftover: got %0d entries required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_channel_bank.md
IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of I/O channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, width of each INPR/OUTR.
REQ-003 SHALL have parameter PRIO_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 myclock  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 ch_in_valid  in  NUM_CH  per-channel pulse: device input arrived.
REQ-008 ch_in_data  in  NUM_CH*DATA_W  device input bytes; channel k at bits [k*DATA_W +: DATA_W].
REQ-009 ch_out_ready  in  NUM_CH  per-channel pulse: device consumed output.
REQ-010 ch_out_data  out  NUM_CH*DATA_W  OUTR contents per channel.
REQ-011 ch_out_valid  out  NUM_CH  per-channel ~FGO (output pending).
REQ-012 sel  in  CH_W  CPU-selected channel, CH_W = max(1, clog2(NUM_CH)).
REQ-013 bus_in  in  DATA_W  AC low byte for OUT.
REQ-014 cpu_inp, cpu_out, cpu_ion, cpu_iof  in  1 each  single-cycle CPU I/O strobes.
REQ-015 inp_data  out  DATA_W  INPR[sel], combinational.
REQ-016 fgi_sel, fgo_sel  out  1 each  FGI[sel], FGO[sel], combinational (SKI/SKO).
REQ-017 r_sample  in  1  high when sequencer is outside T0..T2.
REQ-018 int_ack  in  1  interrupt cycle entered.
REQ-019 r_out  out  1  interrupt flip-flop R.
REQ-020 int_vec  out  CH_W  channel that caused current R.
REQ-021 ien_out  out  1  IEN state.
REQ-022 overrun  out  NUM_CH  sticky per-channel input-overrun flags.

Function
REQ-023 On ch_in_valid[k] with FGI[k]=0: INPR[k] SHALL latch ch_in_data[k] and FGI[k] SHALL set next cycle.
REQ-024 On ch_in_valid[k] with FGI[k]=1 and no same-cycle read: data SHALL be dropped, overrun[k] SHALL set.
REQ-025 cpu_inp SHALL clear FGI[sel]; if ch_in_valid[sel] coincides, new data SHALL be latched and FGI stays 1 (set wins, no overrun).
REQ-026 cpu_out with FGO[sel]=1 SHALL load OUTR[sel] from bus_in and clear FGO[sel]; with FGO[sel]=0 it SHALL be ignored.
REQ-027 ch_out_ready[k] while FGO[k]=0 SHALL set FGO[k] next cycle; otherwise ignored.
REQ-028 cpu_ion SHALL set IEN, cpu_iof SHALL clear IEN; both together: clear wins.
REQ-029 pending[k] = FGI[k] | FGO[k].
REQ-030 R SHALL set when r_sample & IEN & |pending & ~R; int_vec SHALL latch the winning channel in the same edge.
REQ-031 PRIO_MODE=0: winner = lowest pending index; PRIO_MODE=1: winner = first pending index at or after rr_ptr, wrapping NUM_CH-1 -> 0.
REQ-032 int_ack SHALL clear R and IEN next cycle, dominating cpu_ion and R-set; in PRIO_MODE=1 rr_ptr SHALL become (int_vec+1) mod NUM_CH.
REQ-033 int_vec SHALL hold while R=1; pending changes during R=1 SHALL NOT alter it.
REQ-034 Reads of overrun SHALL NOT clear it; only cpu_inp on that channel SHALL clear overrun[sel].
REQ-035 sel >= NUM_CH: strobes SHALL be ignored, inp_data/fgi_sel/fgo_sel SHALL read 0.

Reset
REQ-036 Reset SHALL force: INPR=0, OUTR=0, FGI=0, FGO=1 (all ready), overrun=0, IEN=0, R=0, int_vec=0, rr_ptr=0.
REQ-037 Reset mid-transfer SHALL discard pending strobes; first post-reset edge behaves as fresh state.

Structure
REQ-038 Shared package SHALL hold PRIO_FIXED/PRIO_RR constants and the CH_W width function.
REQ-039 Per-channel INPR/FGI/OUTR/FGO/overrun SHALL be a sub-module io_channel, instantiated NUM_CH times; arbitration and IEN/R stay in top.

Verification
REQ-040 NUM_CH=2: ch_in_valid[1] with 0x41 -> FGI[1]=1 next cycle; sel=1, cpu_inp -> inp_data=0x41, FGI[1]=0.
REQ-041 Second ch_in_valid[0] (0x55) before read of first (0x33) -> INPR[0]=0x33, overrun[0]=1 until cpu_inp on ch0.
REQ-042 cpu_out sel=0 bus_in=0x7E -> ch_out_valid[0]=1, ch_out_data ch0=0x7E; ch_out_ready[0] -> FGO[0]=1; second cpu_out while FGO=0 leaves 0x7E.
REQ-043 IEN=1, r_sample=1, FGI[0] and FGI[1] set, PRIO_MODE=0 -> R=1, int_vec=0; int_ack -> R=0, IEN=0.
REQ-044 PRIO_MODE=1, NUM_CH=4, channels 0 and 2 always pending: successive ack/ION rounds -> int_vec 0,2,0,2.
REQ-045 Assert reset while R=1 and FGO[1]=0 -> R=0, IEN=0, FGO=all ones, asynchronously before next edge.
